wb_write_port: RTL and testbench

//  Writer side of the 32x32 register file write port. Buffers completed results from the ALU path
//  and the load (memory) path and drives one register-file write per clock. Handles JAL link

---
 rtl/wb_write_port.sv | 198 +++++++++++++++++++
 tb/tb_wb_write_port.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_port.sv
// wb_write_port: writer side of the 32x32 register-file write port.
// Buffers ALU results in a small in-order FIFO and load results in a
// one-entry holding register, then issues at most one register-file write
// per clock. Loads drain ahead of the ALU FIFO head. JAL link entries are
// turned into r31 <= pc+4 at enqueue time, and writes to r0 are consumed
// without raising reg_write.
//
// Optional feature macro: WB_SCOREBOARD_EN
//   Adds output pending[31:0]; bit n is high while any buffered entry
//   targets rn (bit 0 is always low). Without the macro there is no pending
//   port and no scoreboard logic.
//
// Handshake: a beat transfers on the posedge where valid && ready. Both
// ready outputs are decoded from registered state only, so valid never
// feeds back into ready combinationally; a producer may hold valid and
// change payload only after the beat has transferred.

module wb_write_port #(
  parameter int ALU_DEPTH = 2,
  parameter int DW        = 32,
  parameter int AW        = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  input  logic          alu_link,
  input  logic [DW-1:0] alu_pc,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_dest,
  input  logic [DW-1:0] mem_data,
  output logic          reg_write,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [31:0]   pending
`endif
);

  localparam int PW = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
  localparam int CW = $clog2(ALU_DEPTH + 1);

  // ALU FIFO storage and control
  logic [AW-1:0] fifo_dest_q [ALU_DEPTH];
  logic [DW-1:0] fifo_data_q [ALU_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Load holding register
  logic          hold_full_q, hold_full_d;
  logic [AW-1:0] hold_dest_q, hold_dest_d;
  logic [DW-1:0] hold_data_q, hold_data_d;

  // Registered write-port outputs
  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  // Per-cycle control
  logic          alu_acc;
  logic          mem_acc;
  logic          drain_hold;
  logic          drain_fifo;
  logic [AW-1:0] enq_dest;
  logic [DW-1:0] enq_data;
  logic [AW-1:0] sel_dest;
  logic [DW-1:0] sel_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(ALU_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready flags come from registered occupancy only
  assign alu_ready = (count_q < CW'(ALU_DEPTH));
  assign mem_ready = !hold_full_q;

  assign alu_acc = alu_valid && alu_ready;
  assign mem_acc = mem_valid && mem_ready;

  // A full holding register always wins the port; the FIFO head waits
  assign drain_hold = hold_full_q;
  assign drain_fifo = !hold_full_q && (count_q != '0);

  // Link entries become r31 <= pc+4 (wraps modulo 2^DW)
  assign enq_dest = alu_link ? AW'(31) : alu_dest;
  assign enq_data = alu_link ? (alu_pc + DW'(4)) : alu_data;

  assign sel_dest = hold_full_q ? hold_dest_q : fifo_dest_q[rd_ptr_q];
  assign sel_data = hold_full_q ? hold_data_q : fifo_data_q[rd_ptr_q];

  // Next-state: FIFO pointers/count, holding register and write outputs
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    hold_full_d = hold_full_q;
    hold_dest_d = hold_dest_q;
    hold_data_d = hold_data_q;
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (alu_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (drain_fifo) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({alu_acc, drain_fifo})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (mem_acc) begin
      hold_full_d = 1'b1;
      hold_dest_d = mem_dest;
      hold_data_d = mem_data;
    end else if (drain_hold) begin
      hold_full_d = 1'b0;
    end

    // r0 entries are consumed silently and leave addr/data untouched
    if ((drain_hold || drain_fifo) && (sel_dest != '0)) begin
      reg_write_d = 1'b1;
      wr_addr_d   = sel_dest;
      wr_data_d   = sel_data;
    end
  end

  // Control and output registers; reset drops every buffered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      hold_full_q <= 1'b0;
      hold_dest_q <= '0;
      hold_data_q <= '0;
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      hold_full_q <= hold_full_d;
      hold_dest_q <= hold_dest_d;
      hold_data_q <= hold_data_d;
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (alu_acc) begin
      fifo_dest_q[wr_ptr_q] <= enq_dest;
      fifo_data_q[wr_ptr_q] <= enq_data;
    end
  end

  assign reg_write = reg_write_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (count_q != '0) | hold_full_q | reg_write_q;

`ifdef WB_SCOREBOARD_EN
  logic [ALU_DEPTH-1:0] slot_live;

  // Mark which FIFO slots currently hold a buffered entry
  always_comb begin
    slot_live = '0;
    for (int k = 0; k < ALU_DEPTH; k++) begin
      int off;
      off = k - int'(rd_ptr_q);
      if (off < 0) off = off + ALU_DEPTH;
      slot_live[k] = (off < int'(count_q));
    end
  end

  // Pending bit per register: set while any buffered entry targets it
  always_comb begin
    pending = '0;
    for (int n = 1; n < 32; n++) begin
      if (hold_full_q && (hold_dest_q == AW'(n))) pending[n] = 1'b1;
      for (int k = 0; k < ALU_DEPTH; k++) begin
        if (slot_live[k] && (fifo_dest_q[k] == AW'(n))) pending[n] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Testbench for wb_write_port: directed vector table, hand-written
// multi-cycle sequences (reset mid-burst, FIFO full, scoreboard) and a
// randomized phase checked against a queue-based reference model.
module tb_wb_write_port;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          alu_valid, alu_ready, alu_link;
  logic [AW-1:0] alu_dest;
  logic [DW-1:0] alu_data, alu_pc;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] mem_data;
  logic          reg_write, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef WB_SCOREBOARD_EN
  logic [31:0]   pending;
`endif

  wb_write_port #(.ALU_DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .alu_link  (alu_link),
    .alu_pc    (alu_pc),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_dest  (mem_dest),
    .mem_data  (mem_data),
    .reg_write (reg_write),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
`ifdef WB_SCOREBOARD_EN
    ,
    .pending   (pending)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        m_fifo[$];
  ent_t        m_hold[$];
  logic        m_rw;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] seen_q[$];

  task automatic model_clear();
    m_fifo.delete();
    m_hold.delete();
    m_rw   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (m_fifo[i]) p[m_fifo[i].dest] = 1'b1;
    foreach (m_hold[i]) p[m_hold[i].dest] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                       input logic al, input logic [31:0] apc,
                       input logic mv, input logic [4:0] md, input logic [31:0] mdata);
    alu_valid = av;
    alu_dest  = ad;
    alu_data  = adata;
    alu_link  = al;
    alu_pc    = apc;
    mem_valid = mv;
    mem_dest  = md;
    mem_data  = mdata;
  endtask

  // One clock with model prediction; outputs compared #1 after the edge
  task automatic mcycle(input string tag,
                        input logic av, input logic [4:0] ad, input logic [31:0] adata,
                        input logic al, input logic [31:0] apc,
                        input logic mv, input logic [4:0] md, input logic [31:0] mdata,
                        output logic a_acc, output logic m_acc);
    logic ar, mr, has;
    ent_t e;
    drive(av, ad, adata, al, apc, mv, md, mdata);
    ar = (m_fifo.size() < DEPTH);
    mr = (m_hold.size() == 0);
    check({tag, ".alu_ready"}, alu_ready, ar);
    check({tag, ".mem_ready"}, mem_ready, mr);
    has = 1'b0;
    if (m_hold.size() != 0) begin
      e = m_hold.pop_front();
      has = 1'b1;
    end else if (m_fifo.size() != 0) begin
      e = m_fifo.pop_front();
      has = 1'b1;
    end
    m_rw = 1'b0;
    if (has && e.dest != 0) begin
      m_rw   = 1'b1;
      m_addr = e.dest;
      m_data = e.data;
    end
    a_acc = av && ar;
    m_acc = mv && mr;
    if (m_acc) m_hold.push_back('{dest: md, data: mdata});
    if (a_acc) m_fifo.push_back(al ? '{dest: 5'd31, data: apc + 32'd4} : '{dest: ad, data: adata});
    @(posedge clk);
    #1;
    if (reg_write === 1'b1) seen_q.push_back(wr_data);
    check({tag, ".reg_write"}, reg_write, m_rw);
    check({tag, ".wr_addr"}, wr_addr, m_addr);
    check({tag, ".wr_data"}, wr_data, m_data);
    check({tag, ".busy"}, busy, (m_fifo.size() != 0) || (m_hold.size() != 0) || m_rw);
`ifdef WB_SCOREBOARD_EN
    check({tag, ".pending"}, pending, model_pending());
`endif
  endtask

  // Asynchronous reset pulse away from the clock edge
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    #1;
    check({tag, ".reg_write"}, reg_write, 1'b0);
    check({tag, ".wr_addr"}, wr_addr, 32'd0);
    check({tag, ".wr_data"}, wr_data, 32'd0);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".alu_ready"}, alu_ready, 1'b1);
    check({tag, ".mem_ready"}, mem_ready, 1'b1);
`ifdef WB_SCOREBOARD_EN
    check({tag, ".pending"}, pending, 32'd0);
`endif
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adata;
    logic        al;
    logic [31:0] apc;
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mdata;
    logic        e_rw;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ar;
    logic        e_mr;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                              input logic al, input logic [31:0] apc,
                              input logic mv, input logic [4:0] md, input logic [31:0] mdata,
                              input logic rw, input logic [4:0] ea, input logic [31:0] ed,
                              input logic ear, input logic emr, input logic eb);
    vec_t v;
    v.av = av; v.ad = ad; v.adata = adata; v.al = al; v.apc = apc;
    v.mv = mv; v.md = md; v.mdata = mdata;
    v.e_rw = rw; v.e_addr = ea; v.e_data = ed; v.e_ar = ear; v.e_mr = emr; v.e_busy = eb;
    return v;
  endfunction

  vec_t tbl[15];

  // ---------------- stimulus ----------------
  initial begin : main
    logic a_acc, m_acc, saw_full;
    int idx;
    logic [31:0] beat_data[3];
    logic found;

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    model_clear();
    repeat (2) @(negedge clk);
    check("reset.reg_write", reg_write, 1'b0);
    check("reset.wr_addr", wr_addr, 32'd0);
    check("reset.wr_data", wr_data, 32'd0);
    check("reset.busy", busy, 1'b0);
    check("reset.alu_ready", alu_ready, 1'b1);
    check("reset.mem_ready", mem_ready, 1'b1);
    rst = 1'b0;

    // Expected values are the outputs just after the edge that samples the inputs
    //          av  ad     adata         al  apc           mv  md     mdata      rw  addr   data          ar  mr  busy
    tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0,  32'h0,        0,  5'd0,  32'h0,     0,  5'd0,  32'h0,        1,  1,  1);
    tbl[1]  = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     1,  5'd5,  32'hDEADBEEF, 1,  1,  1);
    tbl[2]  = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     0,  5'd5,  32'hDEADBEEF, 1,  1,  0);
    tbl[3]  = mk(1, 5'd7,  32'h12345678, 1,  32'h00400010, 0,  5'd0,  32'h0,     0,  5'd5,  32'hDEADBEEF, 1,  1,  1);
    tbl[4]  = mk(1, 5'd3,  32'h0BADF00D, 1,  32'hFFFFFFFC, 0,  5'd0,  32'h0,     1,  5'd31, 32'h00400014, 1,  1,  1);
    tbl[5]  = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     1,  5'd31, 32'h00000000, 1,  1,  1);
    tbl[6]  = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     0,  5'd31, 32'h00000000, 1,  1,  0);
    tbl[7]  = mk(1, 5'd9,  32'h22,       0,  32'h0,        1,  5'd8,  32'h11,    0,  5'd31, 32'h00000000, 1,  0,  1);
    tbl[8]  = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     1,  5'd8,  32'h11,       1,  1,  1);
    tbl[9]  = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     1,  5'd9,  32'h22,       1,  1,  1);
    tbl[10] = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     0,  5'd9,  32'h22,       1,  1,  0);
    tbl[11] = mk(1, 5'd0,  32'h55,       0,  32'h0,        0,  5'd0,  32'h0,     0,  5'd9,  32'h22,       1,  1,  1);
    tbl[12] = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     0,  5'd9,  32'h22,       1,  1,  0);
    tbl[13] = mk(0, 5'd0,  32'h0,        0,  32'h0,        1,  5'd0,  32'h66,    0,  5'd9,  32'h22,       1,  0,  1);
    tbl[14] = mk(0, 5'd0,  32'h0,        0,  32'h0,        0,  5'd0,  32'h0,     0,  5'd9,  32'h22,       1,  1,  0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].av, tbl[i].ad, tbl[i].adata, tbl[i].al, tbl[i].apc,
            tbl[i].mv, tbl[i].md, tbl[i].mdata);
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d].reg_write", i), reg_write, tbl[i].e_rw);
      check($sformatf("tbl[%0d].wr_addr", i), wr_addr, tbl[i].e_addr);
      check($sformatf("tbl[%0d].wr_data", i), wr_data, tbl[i].e_data);
      check($sformatf("tbl[%0d].alu_ready", i), alu_ready, tbl[i].e_ar);
      check($sformatf("tbl[%0d].mem_ready", i), mem_ready, tbl[i].e_mr);
      check($sformatf("tbl[%0d].busy", i), busy, tbl[i].e_busy);
    end
    do_reset("post_tbl");

    // Reset with two FIFO entries buffered
    mcycle("burst0", 1, 5'd1, 32'h101, 0, 32'h0, 1, 5'd2, 32'h202, a_acc, m_acc);
    mcycle("burst1", 1, 5'd3, 32'h303, 0, 32'h0, 0, 5'd0, 32'h0, a_acc, m_acc);
    do_reset("rst_fifo2");
    mcycle("after_rst0", 0, 5'd0, 32'h0, 0, 32'h0, 0, 5'd0, 32'h0, a_acc, m_acc);
    mcycle("after_rst1", 0, 5'd0, 32'h0, 0, 32'h0, 0, 5'd0, 32'h0, a_acc, m_acc);
    // Reset with a FIFO entry and a held load
    mcycle("burst2", 1, 5'd4, 32'h404, 0, 32'h0, 1, 5'd6, 32'h606, a_acc, m_acc);
    do_reset("rst_hold");
    mcycle("after_rst2", 0, 5'd0, 32'h0, 0, 32'h0, 0, 5'd0, 32'h0, a_acc, m_acc);

    // FIFO fills while loads keep the port busy; no ALU beat may be lost
    seen_q.delete();
    beat_data[0] = 32'hA0A0_0000;
    beat_data[1] = 32'hA1A1_1111;
    beat_data[2] = 32'hA2A2_2222;
    saw_full = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (alu_ready === 1'b0) saw_full = 1'b1;
      mcycle($sformatf("full[%0d]", c), (idx < 3), 5'(10 + idx), beat_data[idx % 3], 0, 32'h0,
             (idx < 3), 5'd20, 32'h1000 + 32'(c), a_acc, m_acc);
      if (a_acc) idx++;
    end
    check("full.alu_ready_dropped", saw_full, 1'b1);
    check("full.beats_accepted", 32'(idx), 32'd3);
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      foreach (seen_q[j]) if (seen_q[j] == beat_data[k]) found = 1'b1;
      check($sformatf("full.beat%0d_written", k), found, 1'b1);
    end

`ifdef WB_SCOREBOARD_EN
    // Scoreboard bit follows r12 from acceptance to its write
    mcycle("sb0", 1, 5'd12, 32'h0C0C, 0, 32'h0, 0, 5'd0, 32'h0, a_acc, m_acc);
    check("sb.pend12_set", pending[12], 1'b1);
    mcycle("sb1", 0, 5'd0, 32'h0, 0, 32'h0, 0, 5'd0, 32'h0, a_acc, m_acc);
    check("sb.r12_written", reg_write, 1'b1);
    check("sb.pend12_clear", pending[12], 1'b0);
`endif

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 600; c++) begin
      logic        av, al, mv;
      logic [4:0]  ad, md;
      logic [31:0] apc;
      if ($urandom_range(0, 149) == 0) do_reset($sformatf("rnd_rst[%0d]", c));
      av  = ($urandom_range(0, 2) != 0);
      ad  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      al  = ($urandom_range(0, 5) == 0);
      apc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
      mv  = ($urandom_range(0, 2) == 0);
      md  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mcycle($sformatf("rnd[%0d]", c), av, ad, $urandom, al, apc, mv, md, $urandom, a_acc, m_acc);
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the run is bounded, this only guards against a stuck simulator
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
